fir_param_axis: RTL and testbench

FIR_PARAM_AXIS -- requirements
Module: fir_param_axis

---
 rtl/fir_param_axis.sv | 157 +++++++++++++++
 tb/tb_fir_param_axis.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_param_axis.sv
// Sequential (one MAC per cycle) FIR filter with AXI-Stream style handshakes,
// shift-loaded coefficients and a saturated output.
module fir_param_axis #(
   parameter int TAP_SIZE    = 6,
   parameter int NBR_OF_TAPS = 8,
   parameter int X_N_SIZE    = 8,
   parameter int Y_N_SIZE    = 14
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic signed [X_N_SIZE-1:0] x_n,
   input  logic                       s_axis_fir_tvalid,
   output logic                       s_axis_fir_tready,
   input  logic                       s_set_coeffs,
   input  logic signed [TAP_SIZE-1:0] coeff_in,
   input  logic                       coeff_valid,
   output logic signed [Y_N_SIZE-1:0] y_n,
   output logic                       m_axis_fir_tvalid,
   input  logic                       m_axis_fir_tready,
   output logic                       sat_flag
);

   localparam int KW    = (NBR_OF_TAPS > 1) ? $clog2(NBR_OF_TAPS) : 1;
   localparam int CW    = $clog2(NBR_OF_TAPS + 1);
   localparam int ACC_W = TAP_SIZE + X_N_SIZE + $clog2(NBR_OF_TAPS);

   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (Y_N_SIZE - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(64'sd1 <<< (Y_N_SIZE - 1)));

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONFIG = 2'd1,
      MAC    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                     state_q;
   logic signed [TAP_SIZE-1:0] taps_q  [NBR_OF_TAPS];
   logic signed [X_N_SIZE-1:0] buffs_q [NBR_OF_TAPS];
   logic signed [ACC_W-1:0]    acc_q;
   logic [KW-1:0]              k_q;
   logic [CW-1:0]              cnt_q;
   logic signed [Y_N_SIZE-1:0] y_q;
   logic                       sat_q;
   logic                       vld_q;

   logic signed [ACC_W-1:0]    tap_ext_d;
   logic signed [ACC_W-1:0]    smp_ext_d;
   logic signed [ACC_W-1:0]    acc_d;
   logic signed [Y_N_SIZE-1:0] y_sat_d;
   logic                       sat_d;

   // Clamp a full-precision sum into the output range; MSB of the result is the clamp flag.
   function automatic logic [Y_N_SIZE:0] saturate(input logic signed [ACC_W-1:0] v);
      logic [Y_N_SIZE:0] r;
      if (v > Y_MAX) begin
         r = {1'b1, Y_MAX[Y_N_SIZE-1:0]};
      end else if (v < Y_MIN) begin
         r = {1'b1, Y_MIN[Y_N_SIZE-1:0]};
      end else begin
         r = {1'b0, v[Y_N_SIZE-1:0]};
      end
      return r;
   endfunction

   assign s_axis_fir_tready = (state_q == IDLE) & ~s_set_coeffs;
   assign y_n               = y_q;
   assign sat_flag          = sat_q;
   assign m_axis_fir_tvalid = vld_q;

   // Current MAC step: sign-extended operands, running sum and its clamped form.
   always_comb begin
      tap_ext_d = {{(ACC_W - TAP_SIZE){taps_q[k_q][TAP_SIZE-1]}}, taps_q[k_q]};
      smp_ext_d = {{(ACC_W - X_N_SIZE){buffs_q[k_q][X_N_SIZE-1]}}, buffs_q[k_q]};
      acc_d     = acc_q + tap_ext_d * smp_ext_d;
      {sat_d, y_sat_d} = saturate(acc_d);
   end

   // Control FSM, delay line, coefficient shift register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
         sat_q   <= 1'b0;
         vld_q   <= 1'b0;
         for (int i = 0; i < NBR_OF_TAPS; i++) begin
            buffs_q[i] <= '0;
            taps_q[i]  <= '0;
         end
         taps_q[0] <= TAP_SIZE'(1);
      end else begin
         case (state_q)
            IDLE: begin
               // A coefficient request wins over a sample offered in the same cycle.
               if (s_set_coeffs) begin
                  cnt_q   <= '0;
                  state_q <= CONFIG;
               end else if (s_axis_fir_tvalid) begin
                  buffs_q[0] <= x_n;
                  for (int i = 1; i < NBR_OF_TAPS; i++) begin
                     buffs_q[i] <= buffs_q[i-1];
                  end
                  acc_q   <= '0;
                  k_q     <= '0;
                  state_q <= MAC;
               end else begin
                  state_q <= IDLE;
               end
            end
            CONFIG: begin
               if (coeff_valid) begin
                  taps_q[0] <= coeff_in;
                  for (int i = 1; i < NBR_OF_TAPS; i++) begin
                     taps_q[i] <= taps_q[i-1];
                  end
                  cnt_q <= cnt_q + CW'(1);
               end else begin
                  cnt_q <= cnt_q;
               end
               if (!s_set_coeffs || (coeff_valid && (cnt_q == CW'(NBR_OF_TAPS - 1)))) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= CONFIG;
               end
            end
            MAC: begin
               acc_q <= acc_d;
               if (k_q == KW'(NBR_OF_TAPS - 1)) begin
                  k_q     <= '0;
                  y_q     <= y_sat_d;
                  sat_q   <= sat_d;
                  vld_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            DONE: begin
               if (m_axis_fir_tready) begin
                  vld_q   <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  state_q <= DONE;
               end
            end
            default: begin
               vld_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_param_axis.sv
// Randomized self-checking bench for fir_param_axis against a convolution model
// (y = sum of coefficient[i] * sample[n-i], then clamp to the output range).
module tb_fir_param_axis;

   localparam int N  = 8;
   localparam int TS = 6;
   localparam int XS = 8;
   localparam int YS = 14;

   logic                 clk = 1'b0;
   logic                 reset;
   logic signed [XS-1:0] x_n;
   logic                 s_axis_fir_tvalid;
   logic                 s_axis_fir_tready;
   logic                 s_set_coeffs;
   logic signed [TS-1:0] coeff_in;
   logic                 coeff_valid;
   logic signed [YS-1:0] y_n;
   logic                 m_axis_fir_tvalid;
   logic                 m_axis_fir_tready;
   logic                 sat_flag;

   int     n_checks = 0;
   int     n_errors = 0;
   int     cyc      = 0;
   int     last_acc = 0;
   longint taps_m [N];
   longint hist_m [N];

   fir_param_axis #(
      .TAP_SIZE(TS), .NBR_OF_TAPS(N), .X_N_SIZE(XS), .Y_N_SIZE(YS)
   ) dut (
      .clk(clk), .reset(reset), .x_n(x_n),
      .s_axis_fir_tvalid(s_axis_fir_tvalid), .s_axis_fir_tready(s_axis_fir_tready),
      .s_set_coeffs(s_set_coeffs), .coeff_in(coeff_in), .coeff_valid(coeff_valid),
      .y_n(y_n), .m_axis_fir_tvalid(m_axis_fir_tvalid),
      .m_axis_fir_tready(m_axis_fir_tready), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         taps_m[i] = 0;
         hist_m[i] = 0;
      end
      taps_m[0] = 1;
   endtask

   function automatic void expected(output longint y, output bit f);
      longint s  = 0;
      longint mx = (longint'(1) <<< (YS - 1)) - 1;
      longint mn = -mx - 1;
      for (int i = 0; i < N; i++) s += taps_m[i] * hist_m[i];
      f = 1'b1;
      if (s > mx) y = mx;
      else if (s < mn) y = mn;
      else begin
         y = s;
         f = 1'b0;
      end
   endfunction

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      check_val("rst_y", y_n, 0);
      check_val("rst_vld", m_axis_fir_tvalid, 0);
      check_val("rst_sat", sat_flag, 0);
      check_val("rst_rdy", s_axis_fir_tready, 1);
      model_reset();
      tick();
      reset = 1'b0;
      tick();
      check_val("post_rst_rdy", s_axis_fir_tready, 1);
   endtask

   // Loads cq (oldest first); a queue shorter than N ends the load early.
   task automatic load_coeffs(input longint cq[$]);
      s_set_coeffs = 1'b1;
      #1;
      check_val("cfg_rdy_low", s_axis_fir_tready, 0);
      tick();
      foreach (cq[i]) begin
         if ($urandom_range(0, 3) == 0) begin
            coeff_valid = 1'b0;
            tick();
         end
         coeff_in    = TS'(cq[i]);
         coeff_valid = 1'b1;
         tick();
         for (int j = N - 1; j > 0; j--) taps_m[j] = taps_m[j-1];
         taps_m[0] = cq[i];
      end
      coeff_valid = 1'b0;
      if (cq.size() < N) begin
         s_set_coeffs = 1'b0;
         tick();
      end else begin
         s_set_coeffs = 1'b0;
         #1;
      end
      check_val("cfg_done_rdy", s_axis_fir_tready, 1);
   endtask

   task automatic run_sample(input longint x, input int stall, input bit chk_tp,
                             output longint y_got, output bit sat_got);
      longint ey;
      bit     ef;
      int     waited = 0;
      x_n               = XS'(x);
      s_axis_fir_tvalid = 1'b1;
      m_axis_fir_tready = (stall == 0);
      #1;
      while (!s_axis_fir_tready && waited < 10) begin
         tick();
         waited++;
      end
      check_val("in_rdy", s_axis_fir_tready, 1);
      tick();
      if (chk_tp) check_val("throughput", cyc - last_acc, N + 2);
      last_acc          = cyc;
      s_axis_fir_tvalid = 1'b0;
      for (int j = N - 1; j > 0; j--) hist_m[j] = hist_m[j-1];
      hist_m[0] = x;
      expected(ey, ef);
      for (int i = 1; i < N; i++) tick();
      check_val("lat_early", m_axis_fir_tvalid, 0);
      tick();
      check_val("lat_vld", m_axis_fir_tvalid, 1);
      check_val("y", y_n, ey);
      check_val("sat", sat_flag, ef);
      y_got   = y_n;
      sat_got = sat_flag;
      if (stall > 0) begin
         s_axis_fir_tvalid = 1'b1;
         x_n               = XS'($urandom_range(0, 255));
         for (int s = 0; s < stall; s++) begin
            tick();
            check_val("stall_y", y_n, ey);
            check_val("stall_vld", m_axis_fir_tvalid, 1);
            check_val("stall_rdy", s_axis_fir_tready, 0);
         end
         m_axis_fir_tready = 1'b1;
      end
      tick();
      s_axis_fir_tvalid = 1'b0;
      check_val("rel_vld", m_axis_fir_tvalid, 0);
      check_val("rel_rdy", s_axis_fir_tready, 1);
   endtask

   initial begin
      longint y;
      bit     f;
      longint cq[$];

      reset             = 1'b1;
      x_n               = '0;
      s_axis_fir_tvalid = 1'b0;
      s_set_coeffs      = 1'b0;
      coeff_in          = '0;
      coeff_valid       = 1'b0;
      m_axis_fir_tready = 1'b1;
      tick();
      tick();
      apply_reset();

      run_sample(5, 0, 1'b0, y, f);
      check_val("pass5_y", y, 5);
      check_val("pass5_sat", f, 0);

      apply_reset();
      cq = {};
      for (int i = 0; i < N; i++) cq.push_back(1);
      load_coeffs(cq);
      run_sample(10, 0, 1'b0, y, f);
      check_val("ones_first", y, 10);
      for (int i = 0; i < 7; i++) begin
         run_sample(0, 0, 1'b1, y, f);
         check_val("ones_tail", y, 10);
      end
      run_sample(0, 0, 1'b1, y, f);
      check_val("ones_ninth", y, 0);

      apply_reset();
      cq = {};
      for (int i = 0; i < N; i++) cq.push_back(-32);
      load_coeffs(cq);
      for (int i = 0; i < N; i++) run_sample(-128, 0, 1'b0, y, f);
      check_val("sat_hi_y", y, 8191);
      check_val("sat_hi_f", f, 1);
      run_sample(0, 0, 1'b0, y, f);
      check_val("sat7_y", y, 8191);
      check_val("sat7_f", f, 1);

      run_sample(int'($urandom_range(0, 255)) - 128, 20, 1'b0, y, f);
      run_sample(-100, 0, 1'b0, y, f);

      // Coefficient request and sample together: request wins, sample dropped.
      s_set_coeffs      = 1'b1;
      s_axis_fir_tvalid = 1'b1;
      x_n               = XS'(99);
      #1;
      check_val("both_rdy", s_axis_fir_tready, 0);
      tick();
      s_set_coeffs      = 1'b0;
      s_axis_fir_tvalid = 1'b0;
      tick();
      check_val("both_idle_rdy", s_axis_fir_tready, 1);
      run_sample(-77, 0, 1'b0, y, f);

      // Reset in the middle of a MAC sequence.
      x_n               = XS'(42);
      s_axis_fir_tvalid = 1'b1;
      tick();
      s_axis_fir_tvalid = 1'b0;
      tick();
      tick();
      tick();
      apply_reset();
      check_val("abort_vld", m_axis_fir_tvalid, 0);
      run_sample(37, 0, 1'b0, y, f);
      check_val("ident_y", y, 37);

      // Reset in the middle of a coefficient load.
      s_set_coeffs = 1'b1;
      tick();
      coeff_in    = TS'(9);
      coeff_valid = 1'b1;
      tick();
      coeff_valid  = 1'b0;
      s_set_coeffs = 1'b0;
      apply_reset();
      run_sample(-19, 0, 1'b0, y, f);
      check_val("ident2_y", y, -19);

      for (int r = 0; r < 6; r++) begin
         int len = (r == 3) ? int'($urandom_range(1, N - 1)) : N;
         cq = {};
         for (int i = 0; i < len; i++) cq.push_back(int'($urandom_range(0, 63)) - 32);
         load_coeffs(cq);
         for (int j = 0; j < 10; j++) begin
            run_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 2)),
                       1'b0, y, f);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
